// File: rtl/fully_connected_layer_multi_core.sv
// Fully connected layer with NUM_CORES parallel MAC lanes: one neuron per lane per group,
// followed by per-neuron bias, arithmetic-shift requantisation, optional ReLU and saturation.
module fully_connected_layer_multi_core #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int INPUT_SIZE  = 784,
    parameter int OUTPUT_SIZE = 10,
    parameter int NUM_CORES   = 4,
    parameter int ACC_WIDTH   = 48,
    parameter int OUT_WIDTH   = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            i_run,
    input  logic                            i_relu_en,
    input  logic [4:0]                      i_shift,
    output logic                            ce_input,
    output logic [ADDR_WIDTH-1:0]           addr_input,
    input  logic [DATA_WIDTH-1:0]           qout_input,
    output logic                            ce_weight,
    output logic [ADDR_WIDTH-1:0]           addr_weight,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] qout_weight,
    output logic                            ce_bias,
    output logic [ADDR_WIDTH-1:0]           addr_bias,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] qout_bias,
    output logic                            ce_output,
    output logic                            we_output,
    output logic [ADDR_WIDTH-1:0]           addr_output,
    output logic [DATA_WIDTH-1:0]           din_output,
    output logic                            busy,
    output logic                            layer_done
);

    localparam int NUM_GROUPS = (OUTPUT_SIZE + NUM_CORES - 1) / NUM_CORES;
    localparam int LAST_K     = OUTPUT_SIZE - (NUM_GROUPS - 1) * NUM_CORES;
    localparam int IW         = $clog2(INPUT_SIZE);
    localparam int GW         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int LW         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int MW         = (2 * DATA_WIDTH > ACC_WIDTH) ? 2 * DATA_WIDTH : ACC_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, POST, WRITE, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [IW-1:0]           in_idx_reg;
    logic [GW-1:0]           grp_reg;
    logic [LW-1:0]           lane_reg;
    logic [ADDR_WIDTH-1:0]   w_base_reg;
    logic [ADDR_WIDTH-1:0]   o_base_reg;
    logic                    relu_en_reg;
    logic [4:0]              shift_reg;
    logic                    valid_reg;
    logic                    first_reg;
    logic                    last_in;
    logic                    last_grp;
    logic                    last_lane;
    logic signed [DATA_WIDTH-1:0] act;
    logic signed [OUT_WIDTH-1:0]  res_lane [NUM_CORES];
    logic signed [OUT_WIDTH-1:0]  res_sel;

    assign act       = qout_input;
    assign last_in   = (in_idx_reg == IW'(INPUT_SIZE - 1));
    assign last_grp  = (grp_reg == GW'(NUM_GROUPS - 1));
    assign last_lane = last_grp ? (lane_reg == LW'(LAST_K - 1))
                                : (lane_reg == LW'(NUM_CORES - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_run) state_next = LOAD;
            LOAD:    if (last_in) state_next = DRAIN;
            DRAIN:   state_next = POST;
            POST:    state_next = WRITE;
            WRITE:   if (last_lane) state_next = last_grp ? DONE : LOAD;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            in_idx_reg  <= '0;
            grp_reg     <= '0;
            lane_reg    <= '0;
            w_base_reg  <= '0;
            o_base_reg  <= '0;
            relu_en_reg <= 1'b0;
            shift_reg   <= '0;
            valid_reg   <= 1'b0;
            first_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Read data returns one cycle after the address, so the MAC enable trails LOAD.
            valid_reg <= (state_reg == LOAD);
            first_reg <= (state_reg == LOAD) && (in_idx_reg == '0);
            case (state_reg)
                IDLE: begin
                    if (i_run) begin
                        relu_en_reg <= i_relu_en;
                        shift_reg   <= i_shift;
                        grp_reg     <= '0;
                        in_idx_reg  <= '0;
                        lane_reg    <= '0;
                        w_base_reg  <= '0;
                        o_base_reg  <= '0;
                    end
                end
                LOAD: in_idx_reg <= last_in ? '0 : in_idx_reg + IW'(1);
                WRITE: begin
                    if (last_lane) begin
                        lane_reg <= '0;
                        if (last_grp) begin
                            grp_reg    <= '0;
                            w_base_reg <= '0;
                            o_base_reg <= '0;
                        end else begin
                            grp_reg    <= grp_reg + GW'(1);
                            w_base_reg <= w_base_reg + ADDR_WIDTH'(INPUT_SIZE);
                            o_base_reg <= o_base_reg + ADDR_WIDTH'(NUM_CORES);
                        end
                    end else begin
                        lane_reg <= lane_reg + LW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_lane
        logic signed [DATA_WIDTH-1:0] weight;
        logic signed [DATA_WIDTH-1:0] bias;
        logic signed [ACC_WIDTH-1:0]  prod;
        logic signed [ACC_WIDTH-1:0]  bias_ext;
        logic signed [ACC_WIDTH-1:0]  acc_reg;
        logic signed [ACC_WIDTH-1:0]  shifted;
        logic signed [ACC_WIDTH-1:0]  lo;
        logic signed [OUT_WIDTH-1:0]  res_next;
        logic signed [OUT_WIDTH-1:0]  res_reg;

        assign weight   = qout_weight[gi*DATA_WIDTH +: DATA_WIDTH];
        assign bias     = qout_bias[gi*DATA_WIDTH +: DATA_WIDTH];
        assign prod     = ACC_WIDTH'(MW'(act) * MW'(weight));
        assign bias_ext = ACC_WIDTH'(MW'(bias));

        // ReLU is folded into the saturation lower bound.
        always_comb begin
            shifted = acc_reg >>> shift_reg;
            lo      = relu_en_reg ? '0 : SAT_MIN;
            if (shifted > SAT_MAX)
                res_next = SAT_MAX[OUT_WIDTH-1:0];
            else if (shifted < lo)
                res_next = lo[OUT_WIDTH-1:0];
            else
                res_next = shifted[OUT_WIDTH-1:0];
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                acc_reg <= '0;
                res_reg <= '0;
            end else begin
                if (valid_reg)
                    acc_reg <= first_reg ? bias_ext + prod : acc_reg + prod;
                if (state_reg == POST)
                    res_reg <= res_next;
            end
        end

        assign res_lane[gi] = res_reg;
    end

    always_comb begin
        res_sel = '0;
        for (int c = 0; c < NUM_CORES; c++)
            if (lane_reg == LW'(c)) res_sel = res_lane[c];
    end

    assign busy        = (state_reg != IDLE);
    assign layer_done  = (state_reg == DONE);
    assign ce_input    = (state_reg == LOAD);
    assign ce_weight   = (state_reg == LOAD);
    assign ce_bias     = (state_reg == LOAD) && (in_idx_reg == '0);
    assign ce_output   = (state_reg == WRITE);
    assign we_output   = (state_reg == WRITE);
    assign addr_input  = ce_input  ? ADDR_WIDTH'(in_idx_reg) : '0;
    assign addr_weight = ce_weight ? w_base_reg + ADDR_WIDTH'(in_idx_reg) : '0;
    assign addr_bias   = ce_bias   ? ADDR_WIDTH'(grp_reg) : '0;
    assign addr_output = ce_output ? o_base_reg + ADDR_WIDTH'(lane_reg) : '0;
    assign din_output  = ce_output ? DATA_WIDTH'(res_sel) : '0;

endmodule
